// File: rtl/aes_pkg.sv
// Shared AES pipeline constants: block width, legal key sizes and latency helpers.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef enum int {
        AES_KEY_128 = 128,
        AES_KEY_192 = 192,
        AES_KEY_256 = 256
    } aes_key_bits_e;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    function automatic int aes_num_rounds(input int key_bits);
        case (key_bits)
            128:     return 10;
            192:     return 12;
            default: return 14;
        endcase
    endfunction

    // One extra stage covers the initial state ^ key capture ahead of round 1.
    function automatic int aes_pipe_latency(input int key_bits, input int cpr);
        return aes_num_rounds(key_bits) * cpr + 1;
    endfunction

    function automatic bit aes_key_bits_legal(input int key_bits);
        return (key_bits == AES_KEY_128) || (key_bits == AES_KEY_192) || (key_bits == AES_KEY_256);
    endfunction

endpackage

// File: rtl/aes_pipe_fifo.sv
// Result buffer for aes_pipe_ctrl: DEPTH x W synchronous FIFO with a synchronous flush.
module aes_pipe_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 132
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [W-1:0]            wr_data,
    input  logic                    rd_en,
    output logic [W-1:0]            rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (count == (AW+1)'(DEPTH));
    // Reads of an empty buffer return zero so the idle outputs are deterministic.
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en && !full) begin
                mem_d[wr_ptr_q[AW-1:0]] = wr_data;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_en && !empty) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/aes_pipe_ctrl.sv
// Valid/ready controller for a fully pipelined AES datapath with tag tracking and result buffer.
// Define AES_PIPE_CHK_EN to compile simulation-only consistency checks.
module aes_pipe_ctrl
    import aes_pkg::*;
#(
    parameter int KEY_BITS         = 192,
    parameter int CYCLES_PER_ROUND = 2,
    parameter int DEPTH            = 4,
    parameter int TAG_W            = 4
) (
    input  logic                   clk,
    input  logic                   rst_i,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   pipe_load,
    input  logic [AES_BLOCK_W-1:0] res_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   busy
);

    localparam int LATENCY = aes_pipe_latency(KEY_BITS, CYCLES_PER_ROUND);
    localparam int OCC_W   = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        aes_block_t       data;
    } res_entry_t;

    // Handshake: a transfer happens on an edge where valid & ready are both high; valid may
    // not depend on ready, and ready never depends combinationally on out_ready.
    logic               accept, pop;
    logic [LATENCY-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [LATENCY];
    logic [TAG_W-1:0]   tag_d [LATENCY];
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               fifo_wr, fifo_empty, fifo_full;
    logic [OCC_W-1:0]   fifo_count;
    res_entry_t         wr_entry, head;

    assign in_ready  = (occ_q < OCC_W'(DEPTH)) & ~clear;
    assign accept    = in_valid & in_ready;
    assign pipe_load = accept & ~clear;
    assign pop       = out_valid & out_ready & ~clear;
    assign busy      = (occ_q != '0);
    assign out_valid = ~fifo_empty;
    assign out_data  = head.data;
    assign out_tag   = head.tag;

    // Credits are reserved at accept, so the buffer always has room when a block lands.
    assign fifo_wr       = valid_q[LATENCY-1] & ~clear;
    assign wr_entry.tag  = tag_q[LATENCY-1];
    assign wr_entry.data = res_data;

    always_comb begin
        valid_d  = {valid_q[LATENCY-2:0], pipe_load};
        tag_d[0] = in_tag;
        for (int i = 1; i < LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        occ_d = occ_q;
        case ({accept, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
        if (clear) begin
            valid_d = '0;
            occ_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            tag_q   <= tag_d;
        end
    end

    aes_pipe_fifo #(
        .DEPTH (DEPTH),
        .W     (TAG_W + AES_BLOCK_W)
    ) u_fifo (
        .clk     (clk),
        .rst_i   (rst_i),
        .clear   (clear),
        .wr_en   (fifo_wr),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

`ifdef AES_PIPE_CHK_EN
    logic             chk_hold;
    logic [TAG_W-1:0] chk_tag;
    aes_block_t       chk_data;

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            chk_hold <= 1'b0;
        end else begin
            if (occ_q > OCC_W'(DEPTH)) begin
                $display("ASSERTION FAILED: occupancy above DEPTH");
                $finish;
            end
            if (fifo_wr && fifo_full) begin
                $display("ASSERTION FAILED: result write into full buffer");
                $finish;
            end
            if (chk_hold && ((out_data != chk_data) || (out_tag != chk_tag))) begin
                $display("ASSERTION FAILED: head changed under back-pressure");
                $finish;
            end
            if (int'(occ_q) != $countones(valid_q) + int'(fifo_count)) begin
                $display("ASSERTION FAILED: occupancy differs from in-flight plus buffered");
                $finish;
            end
            chk_hold <= out_valid & ~out_ready & ~clear;
            chk_tag  <= out_tag;
            chk_data <= out_data;
        end
    end
`else
    logic unused_chk;
    assign unused_chk = ^{fifo_full, fifo_count};
`endif

endmodule

// File: tb/tb_aes_pipe_ctrl.sv
// Bench for aes_pipe_ctrl: defaults instance with scoreboard, plus LATENCY-15 and LATENCY-21 instances.
module tb_aes_pipe_ctrl;

    localparam int W       = 132;
    localparam int A_LAT   = 25;
    localparam int A_DEPTH = 4;

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic         clear, in_valid, in_ready, pipe_load, out_valid, out_ready, busy;
    logic [3:0]   in_tag, out_tag;
    logic [127:0] res_data, out_data;

    logic         b_clear, b_in_valid, b_in_ready, b_pipe_load, b_out_valid, b_out_ready, b_busy;
    logic [3:0]   b_in_tag, b_out_tag;
    logic [127:0] b_out_data;

    logic         c_clear, c_in_valid, c_in_ready, c_pipe_load, c_out_valid, c_out_ready, c_busy;
    logic [3:0]   c_in_tag, c_out_tag;
    logic [127:0] c_out_data;

    logic [W-1:0] exp_q[$];
    int           due_q[$];
    int           m_occ = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] data_fn(input int c);
        logic [31:0] u;
        u = c;
        return {u * 32'h9E3779B9, ~u, u ^ 32'h5A5AA5A5, u};
    endfunction

    assign res_data = data_fn(cyc);

    aes_pipe_ctrl dut (
        .clk(clk), .rst_i(rst_i), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_tag(in_tag), .pipe_load(pipe_load), .res_data(res_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .busy(busy)
    );

    aes_pipe_ctrl #(.KEY_BITS(256), .CYCLES_PER_ROUND(1), .DEPTH(16), .TAG_W(4)) dut_b (
        .clk(clk), .rst_i(rst_i), .clear(b_clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_tag(b_in_tag), .pipe_load(b_pipe_load), .res_data(res_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_tag(b_out_tag), .busy(b_busy)
    );

    aes_pipe_ctrl #(.KEY_BITS(128), .CYCLES_PER_ROUND(2), .DEPTH(4), .TAG_W(4)) dut_c (
        .clk(clk), .rst_i(rst_i), .clear(c_clear), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_tag(c_in_tag), .pipe_load(c_pipe_load), .res_data(res_data), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .out_tag(c_out_tag), .busy(c_busy)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // One cycle on the default instance: drive at negedge, check against the model, update it.
    task automatic cycle_a(input logic v, input logic [3:0] tag, input logic ordy, input logic clr,
                           output logic acc);
        logic         exp_rdy, exp_ov, do_pop;
        logic [W-1:0] front;
        @(negedge clk);
        in_valid = v; in_tag = tag; out_ready = ordy; clear = clr;
        #1;
        exp_rdy = (m_occ < A_DEPTH) && !clr;
        acc     = v && exp_rdy;
        exp_ov  = (exp_q.size() > 0) && (due_q[0] <= cyc);
        chk("in_ready", in_ready, exp_rdy);
        chk("pipe_load", pipe_load, acc);
        chk("busy", busy, m_occ != 0);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            front = exp_q[0];
            chk("out_tag", out_tag, front[131:128]);
            chk("out_data", out_data, front[127:0]);
        end
        do_pop = exp_ov && ordy && !clr;
        if (do_pop) begin
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
            m_occ--;
        end
        if (acc) begin
            exp_q.push_back({tag, data_fn(cyc + A_LAT)});
            due_q.push_back(cyc + A_LAT + 1);
            m_occ++;
        end
        if (clr) begin
            exp_q.delete();
            due_q.delete();
            m_occ = 0;
        end
    endtask

    task automatic drain_a();
        logic acc;
        for (int i = 0; i < 150 && exp_q.size() > 0; i++) cycle_a(1'b0, 4'd0, 1'b1, 1'b0, acc);
        repeat (3) cycle_a(1'b0, 4'd0, 1'b1, 1'b0, acc);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
        repeat (n) @(negedge clk);
        rst_i = 1'b1;
        exp_q.delete();
        due_q.delete();
        m_occ = 0;
    endtask

    initial begin
        logic         acc;
        logic [3:0]   t;
        int           e0;
        logic [W-1:0] front;
        logic [W-1:0] bq[$];

        clear = 0; in_valid = 0; in_tag = 0; out_ready = 0;
        b_clear = 0; b_in_valid = 0; b_in_tag = 0; b_out_ready = 0;
        c_clear = 0; c_in_valid = 0; c_in_tag = 0; c_out_ready = 0;
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_pipe_load", pipe_load, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_b_in_ready", b_in_ready, 1);
        chk("rst_c_out_valid", c_out_valid, 0);

        // Single request, tag 3.
        cycle_a(1'b1, 4'd3, 1'b1, 1'b0, acc);
        drain_a();

        // Back-pressure: tags 0..5 held until taken, consumer stalled for 40+ cycles.
        t = 0;
        repeat (A_LAT + 45) begin
            cycle_a(1'b1, t, 1'b0, 1'b0, acc);
            if (acc) t++;
        end
        for (int k = 0; k < 80 && t < 6; k++) begin
            cycle_a(1'b1, t, 1'b1, 1'b0, acc);
            if (acc) t++;
        end
        drain_a();

        // Flush with three blocks in flight, then a fresh request.
        cycle_a(1'b1, 4'd1, 1'b1, 1'b0, acc);
        cycle_a(1'b1, 4'd2, 1'b1, 1'b0, acc);
        cycle_a(1'b1, 4'd5, 1'b1, 1'b0, acc);
        repeat (7) cycle_a(1'b0, 4'd0, 1'b1, 1'b0, acc);
        cycle_a(1'b1, 4'd9, 1'b1, 1'b1, acc);
        cycle_a(1'b0, 4'd0, 1'b1, 1'b0, acc);
        cycle_a(1'b1, 4'd7, 1'b1, 1'b0, acc);
        drain_a();

        // Asynchronous reset with two blocks in flight.
        cycle_a(1'b1, 4'd2, 1'b1, 1'b0, acc);
        cycle_a(1'b1, 4'd3, 1'b1, 1'b0, acc);
        repeat (6) cycle_a(1'b0, 4'd0, 1'b1, 1'b0, acc);
        do_reset(2);
        #1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);
        chk("rel_busy", busy, 0);
        repeat (40) cycle_a(1'b0, 4'd0, 1'b1, 1'b0, acc);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 250; i++) begin
            cycle_a($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0, acc);
        end
        drain_a();

        // LATENCY 15, DEPTH 16: sixteen back-to-back blocks.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            b_in_valid = 1'b1; b_in_tag = 4'(i); b_out_ready = 1'b1;
            #1;
            if (i == 0) e0 = cyc;
            chk("b_in_ready", b_in_ready, 1);
            chk("b_pipe_load", b_pipe_load, 1);
            if (i > 0) chk("b_out_valid_early", b_out_valid, 0);
            bq.push_back({4'(i), data_fn(cyc + 15)});
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            b_in_valid = 1'b0;
            #1;
            chk("b_out_valid", b_out_valid, k < 16);
            if (k < 16) begin
                front = bq.pop_front();
                chk("b_out_tag", b_out_tag, front[131:128]);
                chk("b_out_data", b_out_data, front[127:0]);
            end
        end
        chk("b_busy_end", b_busy, 0);

        // LATENCY 21: accept and pop together at occ = DEPTH-1.
        bq.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            c_in_valid = 1'b1; c_in_tag = 4'(8 + i); c_out_ready = 1'b0;
            #1;
            if (i == 0) e0 = cyc;
            chk("c_in_ready", c_in_ready, 1);
            bq.push_back({4'(8 + i), data_fn(cyc + 21)});
        end
        @(negedge clk);
        c_in_valid = 1'b0;
        while (cyc < e0 + 21) @(negedge clk);
        #1;
        chk("c_out_valid_early", c_out_valid, 0);
        @(negedge clk);
        c_in_valid = 1'b1; c_in_tag = 4'd11; c_out_ready = 1'b1;
        #1;
        front = bq.pop_front();
        chk("c_out_valid", c_out_valid, 1);
        chk("c_out_tag", c_out_tag, front[131:128]);
        chk("c_out_data", c_out_data, front[127:0]);
        chk("c_ready_swap", c_in_ready, 1);
        chk("c_pipe_load_swap", c_pipe_load, 1);
        @(negedge clk);
        c_in_valid = 1'b1; c_in_tag = 4'd12; c_out_ready = 1'b0;
        #1;
        front = bq[0];
        chk("c_ready_after_swap", c_in_ready, 1);
        chk("c_out_tag2", c_out_tag, front[131:128]);
        chk("c_out_data2", c_out_data, front[127:0]);
        @(negedge clk);
        c_in_valid = 1'b0;
        #1;
        chk("c_full", c_in_ready, 0);
        chk("c_busy", c_busy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
